simon_iter_core: RTL and testbench

// Generic iterative SIMON 2N/MN block cipher core, one round per clock. Successor to the fixed SIMON64/128 core.

---
 rtl/simon_iter_core.sv | 175 +++++++++++++++++
 tb/tb_simon_iter_core.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/simon_iter_core.sv
// rtl/simon_iter_core.sv - iterative SIMON 2N/MN block cipher core, one round per clock
module simon_iter_core #(
    parameter int N    = 32,
    parameter int M    = 4,
    parameter int T    = 44,
    parameter int ZSEL = 3
) (
    input  logic             clk,
    input  logic             nR,
    input  logic             newKey,
    input  logic [M*N-1:0]   key,
    output logic             ldKey,
    output logic             doneKey,
    input  logic             newData,
    input  logic             enc_dec,
    input  logic [2*N-1:0]   plain,
    output logic             ldData,
    output logic             doneData,
    input  logic             readData,
    output logic [2*N-1:0]   cipher,
    output logic             busy
);

    localparam int CW = (T > 1) ? $clog2(T) : 1;
    localparam logic [CW-1:0] LAST = CW'(T - 1);

    function automatic logic [63:0] z_const(input int sel);
        case (sel)
            0:       return 64'h3E8958737D12B0E6;
            1:       return 64'h23BE4C2D477C985A;
            2:       return 64'h2BDC0D262847E5B3;
            3:       return 64'h36EB19781229CD0F;
            default: return 64'h3479AD88170CA4EF;
        endcase
    endfunction

    // z bit j of the sequence lives at position 61-j
    localparam logic [63:0] ZSEQ = z_const(ZSEL);

    typedef enum logic [1:0] {S_IDLE, S_KEYEXP, S_RUN, S_DONE} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          key_arm, key_pend, data_arm, data_pend;
    logic          key_go, data_go;

    logic [N-1:0]  rk_mem [T];
    logic [N-1:0]  kwin [M];
    logic [N-1:0]  knew, ktmp;
    logic [5:0]    z_idx;

    logic [N-1:0]  x, y, x_nxt, rk_cur, fx;
    logic          mode;
    logic [CW-1:0] rk_addr;

    assign key_go  = (state == S_IDLE) && (key_pend || (newKey && key_arm));
    assign data_go = (state == S_IDLE) && !key_go && doneKey &&
                     (data_pend || (newData && data_arm));
    assign busy    = (state != S_IDLE);

    // kwin holds rk[i..i+M-1] at key step i, so the new word is rk[i+M]
    always_comb begin
        ktmp = {kwin[M-1][2:0], kwin[M-1][N-1:3]};
        if (M == 4) ktmp = ktmp ^ kwin[1];
        ktmp = ktmp ^ {ktmp[0], ktmp[N-1:1]};
        knew = ~kwin[0] ^ ktmp ^ {{(N-1){1'b0}}, ZSEQ[6'd61 - z_idx]} ^ N'(3);
    end

    // decryption walks the schedule backwards on word-swapped state
    assign rk_addr = mode ? cnt : (LAST - cnt);
    assign rk_cur  = rk_mem[rk_addr];
    assign fx      = ({x[N-2:0], x[N-1]} & {x[N-9:0], x[N-1:N-8]}) ^ {x[N-3:0], x[N-1:N-2]};
    assign x_nxt   = y ^ fx ^ rk_cur;

    always_ff @(posedge clk) begin
        if (key_go) begin
            for (int j = 0; j < M; j++) kwin[j] <= key[j*N +: N];
            z_idx <= 6'd0;
        end else if (state == S_KEYEXP) begin
            for (int j = 0; j < M - 1; j++) kwin[j] <= kwin[j+1];
            kwin[M-1]    <= knew;
            rk_mem[cnt]  <= kwin[0];
            z_idx        <= (z_idx == 6'd61) ? 6'd0 : z_idx + 6'd1;
        end

        if (data_go) begin
            mode <= enc_dec;
            x    <= enc_dec ? plain[2*N-1:N] : plain[N-1:0];
            y    <= enc_dec ? plain[N-1:0]   : plain[2*N-1:N];
        end else if (state == S_RUN) begin
            x <= x_nxt;
            y <= x;
        end
    end

    always_ff @(posedge clk or negedge nR) begin
        if (!nR) begin
            state     <= S_IDLE;
            cnt       <= '0;
            ldKey     <= 1'b0;
            doneKey   <= 1'b0;
            ldData    <= 1'b0;
            doneData  <= 1'b0;
            cipher    <= '0;
            key_arm   <= 1'b1;
            key_pend  <= 1'b0;
            data_arm  <= 1'b1;
            data_pend <= 1'b0;
        end else begin
            ldKey  <= 1'b0;
            ldData <= 1'b0;

            // a request seen while busy is remembered until IDLE serves it
            if (key_go) begin
                key_pend <= 1'b0;
                key_arm  <= 1'b0;
            end else if (newKey && key_arm) begin
                key_pend <= 1'b1;
                key_arm  <= 1'b0;
            end else if (!newKey) begin
                key_arm  <= 1'b1;
            end

            if (data_go) begin
                data_pend <= 1'b0;
                data_arm  <= 1'b0;
            end else if (newData && data_arm) begin
                data_pend <= 1'b1;
                data_arm  <= 1'b0;
            end else if (!newData) begin
                data_arm  <= 1'b1;
            end

            case (state)
                S_IDLE: begin
                    if (key_go) begin
                        doneKey <= 1'b0;
                        ldKey   <= 1'b1;
                        cnt     <= '0;
                        state   <= S_KEYEXP;
                    end else if (data_go) begin
                        ldData  <= 1'b1;
                        cnt     <= '0;
                        state   <= S_RUN;
                    end
                end
                S_KEYEXP: begin
                    if (cnt == LAST) begin
                        doneKey <= 1'b1;
                        state   <= S_IDLE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_RUN: begin
                    if (cnt == LAST) begin
                        cipher   <= mode ? {x_nxt, x} : {x, x_nxt};
                        doneData <= 1'b1;
                        state    <= S_DONE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_DONE: begin
                    if (readData) begin
                        doneData <= 1'b0;
                        state    <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_simon_iter_core.sv
// tb/tb_simon_iter_core.sv - self-checking bench for simon_iter_core (SIMON64/128 and SIMON32/64)
`timescale 1ns/1ps
module tb_simon_iter_core;

    localparam int T0 = 44;
    localparam int T1 = 32;
    localparam logic [127:0] V1_KEY = 128'h1b1a1918_13121110_0b0a0908_03020100;
    localparam logic [63:0]  V1_PT  = 64'h656b696c20646e75;
    localparam logic [63:0]  V1_CT  = 64'h44c8fc20b9dfa07a;
    localparam logic [127:0] V2_KEY = 128'h1918_1110_0908_0100;
    localparam logic [63:0]  V2_PT  = 64'h65656877;
    localparam logic [63:0]  V2_CT  = 64'hc69be9bb;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         nr;
    logic         nk0, nd0, ed0, rd0, nk1, nd1, ed1, rd1;
    logic [127:0] key0;
    logic [63:0]  key1;
    logic [63:0]  pl0;
    logic [31:0]  pl1;
    logic         lk0, dk0, ldd0, dd0, b0, lk1, dk1, ldd1, dd1, b1;
    logic [63:0]  c0;
    logic [31:0]  c1;

    int n_pass = 0;
    int n_total = 0;
    int n_fail = 0;

    simon_iter_core #(.N(32), .M(4), .T(T0), .ZSEL(3)) u0 (
        .clk(clk), .nR(nr), .newKey(nk0), .key(key0), .ldKey(lk0), .doneKey(dk0),
        .newData(nd0), .enc_dec(ed0), .plain(pl0), .ldData(ldd0), .doneData(dd0),
        .readData(rd0), .cipher(c0), .busy(b0)
    );

    simon_iter_core #(.N(16), .M(4), .T(T1), .ZSEL(0)) u1 (
        .clk(clk), .nR(nr), .newKey(nk1), .key(key1), .ldKey(lk1), .doneKey(dk1),
        .newData(nd1), .enc_dec(ed1), .plain(pl1), .ldData(ldd1), .doneData(dd1),
        .readData(rd1), .cipher(c1), .busy(b1)
    );

    function automatic logic [63:0] mask(int n);
        return (n >= 64) ? '1 : ((64'd1 << n) - 64'd1);
    endfunction

    function automatic logic [63:0] rol(logic [63:0] v, int s, int n);
        logic [63:0] w;
        w = v & mask(n);
        return ((w << s) | (w >> (n - s))) & mask(n);
    endfunction

    function automatic logic [63:0] f_fn(logic [63:0] v, int n);
        return (rol(v, 1, n) & rol(v, 8, n)) ^ rol(v, 2, n);
    endfunction

    // Straight textbook SIMON with M=4: full schedule, then forward or inverse rounds
    function automatic logic [63:0] simon_ref(int n, int t, int zs, logic [127:0] k, bit enc,
                                             logic [63:0] blk);
        string       zstr;
        logic [63:0] rk [72];
        logic [63:0] tmp, x, y, nx, mk;
        if (zs == 0) zstr = "11111010001001010110000111001101111101000100101011000011100110";
        else         zstr = "11011011101011000110010111100000010010001010011100110100001111";
        mk = mask(n);
        for (int i = 0; i < 4; i++) rk[i] = 64'(k >> (i * n)) & mk;
        for (int i = 4; i < t; i++) begin
            tmp = rol(rk[i-1], n - 3, n);
            tmp = tmp ^ rk[i-3];
            tmp = tmp ^ rol(tmp, n - 1, n);
            rk[i] = (~rk[i-4] ^ tmp ^ ((zstr[(i-4) % 62] == "1") ? 64'd1 : 64'd0) ^ 64'd3) & mk;
        end
        x = (blk >> n) & mk;
        y = blk & mk;
        if (enc) begin
            for (int r = 0; r < t; r++) begin
                nx = y ^ f_fn(x, n) ^ rk[r];
                y  = x;
                x  = nx;
            end
        end else begin
            for (int r = t - 1; r >= 0; r--) begin
                nx = y;
                y  = x ^ f_fn(nx, n) ^ rk[r];
                x  = nx;
            end
        end
        return (x << n) | y;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [4:0] flags(int s);
        return (s != 0) ? {lk1, dk1, ldd1, dd1, b1} : {lk0, dk0, ldd0, dd0, b0};
    endfunction

    function automatic logic [63:0] ciph(int s);
        return (s != 0) ? {32'd0, c1} : c0;
    endfunction

    function automatic int t_of(int s);
        return (s != 0) ? T1 : T0;
    endfunction

    task automatic set_nk(int s, logic v); if (s != 0) nk1 = v; else nk0 = v; endtask
    task automatic set_nd(int s, logic v); if (s != 0) nd1 = v; else nd0 = v; endtask
    task automatic set_rd(int s, logic v); if (s != 0) rd1 = v; else rd0 = v; endtask

    task automatic set_key(int s, logic [127:0] k);
        if (s != 0) key1 = k[63:0]; else key0 = k;
    endtask

    task automatic set_block(int s, bit enc, logic [63:0] blk);
        if (s != 0) begin ed1 = enc; pl1 = blk[31:0]; end
        else        begin ed0 = enc; pl0 = blk; end
    endtask

    function automatic logic [63:0] model(int s, logic [127:0] k, bit enc, logic [63:0] blk);
        return (s != 0) ? simon_ref(16, T1, 0, k, enc, blk) : simon_ref(32, T0, 3, k, enc, blk);
    endfunction

    task automatic load_key(int s, logic [127:0] k);
        int lk_c, dk_c;
        logic [4:0] f;
        lk_c = 0;
        dk_c = 0;
        set_key(s, k);
        set_nk(s, 1'b1);
        for (int c = 1; c <= 400 && dk_c == 0; c++) begin
            tick();
            f = flags(s);
            if (f[4] && lk_c == 0) begin
                lk_c = c;
                set_nk(s, 1'b0);
            end
            if (f[3]) dk_c = c;
        end
        set_nk(s, 1'b0);
        check("ldkey_latency", 64'(lk_c), 64'd1);
        check("donekey_latency", 64'(dk_c), 64'(t_of(s) + 1));
    endtask

    task automatic do_block(int s, bit enc, logic [63:0] blk, logic [63:0] exp, string tag);
        int ld_c, dd_c;
        logic [4:0] f;
        ld_c = 0;
        dd_c = 0;
        set_block(s, enc, blk);
        set_nd(s, 1'b1);
        for (int c = 1; c <= 400 && dd_c == 0; c++) begin
            tick();
            f = flags(s);
            if (f[2] && ld_c == 0) begin
                ld_c = c;
                set_nd(s, 1'b0);
            end
            if (f[1]) dd_c = c;
        end
        set_nd(s, 1'b0);
        check({tag, "_ld_lat"}, 64'(ld_c), 64'd1);
        check({tag, "_done_lat"}, 64'(dd_c), 64'(t_of(s) + 1));
        check({tag, "_cipher"}, ciph(s), exp);
        repeat (3) tick();
        check({tag, "_hold"}, {62'd0, flags(s)[1:0]} ^ (ciph(s) << 2), 64'd3 ^ (exp << 2));
        set_rd(s, 1'b1);
        tick();
        set_rd(s, 1'b0);
        check({tag, "_release"}, 64'(flags(s) & 5'b00111), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1);
    end

    initial begin
        logic [127:0] rkey;
        logic [63:0]  blk, res, capture;
        logic [4:0]   f;
        int           ld_cnt, ld_seen;
        bit           got;

        nr = 1'b0;
        {nk0, nd0, ed0, rd0, nk1, nd1, ed1, rd1} = '0;
        key0 = '0; key1 = '0; pl0 = '0; pl1 = '0;
        repeat (3) tick();
        check("reset_flags_u0", 64'(flags(0)), 64'd0);
        check("reset_cipher_u0", ciph(0), 64'd0);
        check("reset_flags_u1", 64'(flags(1)), 64'd0);
        nr = 1'b1;
        tick();

        // data request raised before any key exists, and held high throughout
        set_block(0, 1'b1, V1_PT);
        set_nd(0, 1'b1);
        ld_cnt = 0;
        repeat (6) begin
            tick();
            if (flags(0)[2]) ld_cnt++;
        end
        check("no_ld_before_key", 64'(ld_cnt), 64'd0);
        set_key(0, V1_KEY);
        set_nk(0, 1'b1);
        got = 1'b0;
        capture = '0;
        for (int c = 0; c < 200; c++) begin
            tick();
            set_rd(0, 1'b0);
            f = flags(0);
            if (f[4]) set_nk(0, 1'b0);
            if (f[2]) ld_cnt++;
            if (f[1] && !got) begin
                got = 1'b1;
                capture = c0;
                set_rd(0, 1'b1);
            end
        end
        set_nk(0, 1'b0);
        check("one_ld_while_held", 64'(ld_cnt), 64'd1);
        check("pending_v1_cipher", capture, V1_CT);
        check("idle_while_held", 64'(flags(0)), 64'b01000);
        set_nd(0, 1'b0);
        tick();

        do_block(0, 1'b1, V1_PT, V1_CT, "v1_enc");
        do_block(0, 1'b0, V1_CT, V1_PT, "v1_dec");

        rkey = {$urandom, $urandom, $urandom, $urandom};
        load_key(0, rkey);
        for (int i = 0; i < 4; i++) begin
            blk = {$urandom, $urandom};
            res = model(0, rkey, 1'b1, blk);
            do_block(0, 1'b1, blk, res, "rnd_enc");
            do_block(0, 1'b0, res, blk, "rnd_dec");
        end

        load_key(1, V2_KEY);
        do_block(1, 1'b1, V2_PT, V2_CT, "v2_enc");
        do_block(1, 1'b0, V2_CT, V2_PT, "v2_dec");
        rkey = {64'd0, $urandom, $urandom};
        load_key(1, rkey);
        for (int i = 0; i < 2; i++) begin
            blk = {32'd0, $urandom};
            do_block(1, 1'b1, blk, model(1, rkey, 1'b1, blk), "rnd16_enc");
            blk = {32'd0, $urandom};
            do_block(1, 1'b0, blk, model(1, rkey, 1'b0, blk), "rnd16_dec");
        end

        // reset around round 10 of a running block
        set_block(0, 1'b1, {$urandom, $urandom});
        set_nd(0, 1'b1);
        ld_seen = 0;
        for (int c = 0; c < 10 && ld_seen == 0; c++) begin
            tick();
            if (flags(0)[2]) ld_seen = 1;
        end
        set_nd(0, 1'b0);
        check("abort_run_started", 64'(ld_seen), 64'd1);
        repeat (10) tick();
        nr = 1'b0;
        #2;
        check("abort_flags", 64'(flags(0)), 64'd0);
        check("abort_cipher", ciph(0), 64'd0);
        tick();
        nr = 1'b1;
        repeat (3) tick();
        check("abort_no_key", 64'(flags(0)), 64'd0);
        load_key(0, V1_KEY);
        do_block(0, 1'b1, V1_PT, V1_CT, "v1_after_abort");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
